adder_share_arbiter: RTL and testbench

- Shares one registered ADDER_WIDTH-bit adder (operand registers, then sum register) among NUM_REQ requesters.
- Each requester uses a valid/ready request channel. A round-robin arbiter selects one request per cycle.
- Results return on a single valid/ready response channel, tagged with the requester index.
- Sits between the arithmetic benchmark clients and the shared adder datapath. Full throughput: one add per cycle when there is no backpressure.

---
 rtl/adder_share_arbiter_pkg.sv | 25 ++
 rtl/adder_share_arbiter_rr_arbiter.sv | 72 +++++++
 rtl/adder_share_arbiter.sv | 170 +++++++++++++++++
 tb/tb_adder_share_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_share_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : adder_arb_pkg
//  Description : Shared definitions for the shared-adder arbiter: default
//                sizing, the tag-width helper and the operand/sum/id types.
//  Revision    : 1.0 - initial release
// ============================================================================
package adder_arb_pkg;

  localparam int ADDER_WIDTH_DEFAULT = 65;
  localparam int NUM_REQ_DEFAULT     = 4;

  // Tag width for n requesters; never narrower than one bit.
  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int ID_W_DEFAULT = id_width(NUM_REQ_DEFAULT);

  typedef logic [ADDER_WIDTH_DEFAULT-1:0] operand_t;
  typedef logic [ADDER_WIDTH_DEFAULT:0]   sum_t;
  typedef logic [ID_W_DEFAULT-1:0]        id_t;

endpackage
`default_nettype wire

// File: rtl/adder_share_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Round-robin arbiter. The search starts at rr_ptr and wraps
//                upward; the pointer moves past the winner whenever a grant
//                is taken (advance high with any request present).
//  Ports       : clk, rst       - clock, async active-high reset
//                req            - request vector
//                advance        - downstream can take the granted request
//                grant          - one-hot grant (zero when no request)
//                grant_idx      - binary index of the granted requester
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter
  import adder_arb_pkg::*;
#(
  parameter  int NUM_REQ = NUM_REQ_DEFAULT,
  localparam int ID_W    = id_width(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx
);

  logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0] mask;
  logic [NUM_REQ-1:0] req_hi;
  logic [NUM_REQ-1:0] pick;
  logic               found;

  // Requests at or above the pointer win first; if none, the lowest request
  // below the pointer wins (the wrap-around half of the search).
  always_comb begin
    mask = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      mask[i] = (i >= int'(rr_ptr_q));
    end
    req_hi = req & mask;
    pick   = (|req_hi) ? req_hi : req;

    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && pick[i]) begin
        grant[i]  = 1'b1;
        grant_idx = ID_W'(i);
        found     = 1'b1;
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (advance && found) begin
      rr_ptr_d = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/adder_share_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : adder_share_arbiter
//  Description : Shares one two-stage registered adder among NUM_REQ
//                valid/ready requesters. S1 registers the granted operands,
//                S2 registers the sum; results return tagged with the index
//                of the requester. One add per cycle without backpressure.
//  Ports       : clk, rst          - clock, async active-high reset
//                req_valid/ready   - per-requester handshake (ready one-hot)
//                req_a, req_b      - packed operands, slice i per requester
//                rsp_valid/ready   - result handshake
//                rsp_id, rsp_sum   - requester tag, ADDER_WIDTH+1 bit sum
//                grant_cnt         - per-requester accept counters (stats)
//                stall_cnt         - output stall cycle counter (stats)
//  Options     : ADDER_ARB_STATS_EN adds grant_cnt/stall_cnt saturating
//                16-bit counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module adder_share_arbiter
  import adder_arb_pkg::*;
#(
  parameter  int ADDER_WIDTH = ADDER_WIDTH_DEFAULT,
  parameter  int NUM_REQ     = NUM_REQ_DEFAULT,
  localparam int ID_W        = id_width(NUM_REQ)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ*ADDER_WIDTH-1:0] req_a,
  input  logic [NUM_REQ*ADDER_WIDTH-1:0] req_b,
  output logic                           rsp_valid,
  input  logic                           rsp_ready,
  output logic [ID_W-1:0]                rsp_id,
  output logic [ADDER_WIDTH:0]           rsp_sum
`ifdef ADDER_ARB_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0]          grant_cnt,
  output logic [15:0]                    stall_cnt
`endif
);

  // Stage 1: registered operands
  logic                   v1_q,  v1_d;
  logic [ADDER_WIDTH-1:0] a_q,   a_d;
  logic [ADDER_WIDTH-1:0] b_q,   b_d;
  logic [ID_W-1:0]        id1_q, id1_d;

  // Stage 2: registered result
  logic                   rsp_valid_q, rsp_valid_d;
  logic [ADDER_WIDTH:0]   rsp_sum_q,   rsp_sum_d;
  logic [ID_W-1:0]        rsp_id_q,    rsp_id_d;

  logic                   en1, en2;
  logic [NUM_REQ-1:0]     grant;
  logic [ID_W-1:0]        grant_idx;
  logic [ADDER_WIDTH-1:0] a_sel, b_sel;

  // A stage may load when it is empty or when its contents leave this cycle.
  assign en2 = !rsp_valid_q || rsp_ready;
  assign en1 = !v1_q || en2;

  rr_arbiter #(
    .NUM_REQ   (NUM_REQ)
  ) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (req_valid),
    .advance   (en1),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign req_ready = rst ? '0 : (grant & {NUM_REQ{en1}});

  // Grant is one-hot, so an AND-OR mux selects the winning operands.
  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        a_sel = a_sel | req_a[i*ADDER_WIDTH +: ADDER_WIDTH];
        b_sel = b_sel | req_b[i*ADDER_WIDTH +: ADDER_WIDTH];
      end
    end
  end

  always_comb begin
    v1_d  = v1_q;
    a_d   = a_q;
    b_d   = b_q;
    id1_d = id1_q;
    if (en1) begin
      v1_d  = |grant;
      a_d   = a_sel;
      b_d   = b_sel;
      id1_d = grant_idx;
    end
  end

  // The adder sits alone between the S1 and S2 registers; operands are
  // zero-extended so the MSB of the sum is the carry-out.
  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_sum_d   = rsp_sum_q;
    rsp_id_d    = rsp_id_q;
    if (en2) begin
      rsp_valid_d = v1_q;
      rsp_sum_d   = {1'b0, a_q} + {1'b0, b_q};
      rsp_id_d    = id1_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q        <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      id1_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_sum_q   <= '0;
      rsp_id_q    <= '0;
    end else begin
      v1_q        <= v1_d;
      a_q         <= a_d;
      b_q         <= b_d;
      id1_q       <= id1_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_sum_q   <= rsp_sum_d;
      rsp_id_q    <= rsp_id_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_sum   = rsp_sum_q;
  assign rsp_id    = rsp_id_q;

`ifdef ADDER_ARB_STATS_EN
  logic [NUM_REQ*16-1:0] grant_cnt_q, grant_cnt_d;
  logic [15:0]           stall_cnt_q, stall_cnt_d;

  always_comb begin
    grant_cnt_d = grant_cnt_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_valid[i] && req_ready[i] && (grant_cnt_q[i*16 +: 16] != 16'hFFFF)) begin
        grant_cnt_d[i*16 +: 16] = grant_cnt_q[i*16 +: 16] + 16'd1;
      end
    end
    stall_cnt_d = stall_cnt_q;
    if (rsp_valid_q && !rsp_ready && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      grant_cnt_q <= grant_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign grant_cnt = grant_cnt_q;
  assign stall_cnt = stall_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_adder_share_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_adder_share_arbiter
//  Description : Self-checking bench for adder_share_arbiter. A queue model
//                of the two-deep pipeline is compared against the DUT on
//                every cycle; directed tests add literal expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_adder_share_arbiter;
  import adder_arb_pkg::*;

  localparam int W  = ADDER_WIDTH_DEFAULT;
  localparam int N  = NUM_REQ_DEFAULT;
  localparam int IW = ID_W_DEFAULT;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [IW-1:0]  rsp_id;
  sum_t           rsp_sum;
`ifdef ADDER_ARB_STATS_EN
  logic [N*16-1:0] grant_cnt;
  logic [15:0]     stall_cnt;
`endif

  adder_share_arbiter #(
    .ADDER_WIDTH (W),
    .NUM_REQ     (N)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum)
`ifdef ADDER_ARB_STATS_EN
    ,
    .grant_cnt (grant_cnt),
    .stall_cnt (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // In-flight results in acceptance order; at most two (one per stage).
  // The oldest is presented once two clock edges have passed since accept.
  typedef struct {
    int     id;
    sum_t   sum;
    longint acc;
  } item_t;

  item_t        mq[$];
  int           mptr = 0;
  longint       cyc  = 0;
  int           m_stall = 0;
  int           m_gcnt[N];
  logic [N-1:0] m_g;
  logic         m_ov;
  item_t        m_it;

  function automatic logic model_rsp_valid();
    return (mq.size() > 0) && ((cyc - mq[0].acc) >= 2);
  endfunction

  function automatic logic [N-1:0] model_ready(input logic [N-1:0] v, input logic rr);
    logic [N-1:0] g;
    int idx;
    g = '0;
    if (mq.size() >= 2 && !rr) return g;
    for (int k = 0; k < N; k++) begin
      idx = (mptr + k) % N;
      if (v[idx]) begin
        g[idx] = 1'b1;
        return g;
      end
    end
    return g;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      mptr    = 0;
      m_stall = 0;
      for (int i = 0; i < N; i++) m_gcnt[i] = 0;
    end else begin
      m_ov = model_rsp_valid();
      m_g  = model_ready(req_valid, rsp_ready);
      if (m_ov && !rsp_ready && m_stall < 65535) m_stall++;
      if (m_ov && rsp_ready) void'(mq.pop_front());
      for (int i = 0; i < N; i++) begin
        if (m_g[i]) begin
          m_it.id  = i;
          m_it.sum = {1'b0, req_a[i*W +: W]} + {1'b0, req_b[i*W +: W]};
          m_it.acc = cyc;
          mq.push_back(m_it);
          mptr = (i + 1) % N;
          if (m_gcnt[i] < 65535) m_gcnt[i]++;
        end
      end
      cyc++;
    end
  end

  // ---------------- compare process ----------------
  int     obs_id[$];
  longint obs_cyc[$];
  logic   c_ev;

  always @(negedge clk) begin
    if (rst) begin
      check("rst_rsp_valid", rsp_valid, 1'b0);
      check("rst_req_ready", req_ready, '0);
    end else begin
      c_ev = model_rsp_valid();
      check("req_ready", req_ready, model_ready(req_valid, rsp_ready));
      check("rsp_valid", rsp_valid, c_ev);
      if (c_ev) begin
        check("rsp_id", rsp_id, mq[0].id);
        check("rsp_sum", rsp_sum, mq[0].sum);
      end
`ifdef ADDER_ARB_STATS_EN
      check("stall_cnt", stall_cnt, m_stall);
      for (int i = 0; i < N; i++) check("grant_cnt", grant_cnt[i*16 +: 16], m_gcnt[i]);
`endif
      if (rsp_valid && rsp_ready) begin
        obs_id.push_back(int'(rsp_id));
        obs_cyc.push_back(cyc);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input operand_t a, input operand_t b);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
  endtask

  task automatic check_order(input string name, input int exp_ids[$]);
    check({name, "_count"}, obs_id.size(), exp_ids.size());
    for (int k = 0; k < exp_ids.size() && k < obs_id.size(); k++) begin
      check({name, "_id"}, obs_id[k], exp_ids[k]);
    end
  endtask

  operand_t ones;

  initial begin
    ones      = '1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;

    // Reset: a pending request must not be offered ready while rst is high.
    set_req(0, 9, 9);
    req_valid = 4'b0001;
    repeat (3) tick();
    check("reset_req_ready", req_ready, 4'b0000);
    check("reset_rsp_sum", rsp_sum, 0);
    check("reset_rsp_id", rsp_id, 0);
    req_valid = '0;
    rst       = 1'b0;
    tick();

    // Single request from requester 2: 5+7 two cycles after accept.
    set_req(2, 5, 7);
    req_valid = 4'b0100;
    #1 check("t1_req_ready", req_ready, 4'b0100);
    tick();
    req_valid = '0;
    check("t1_not_yet", rsp_valid, 1'b0);
    tick();
    check("t1_rsp_valid", rsp_valid, 1'b1);
    check("t1_rsp_sum", rsp_sum, 12);
    check("t1_rsp_id", rsp_id, 2);
    tick();
    check("t1_rsp_drop", rsp_valid, 1'b0);

    // Carry-out from requester 3 (pointer now 3).
    set_req(3, ones, ones);
    req_valid = 4'b1000;
    tick();
    req_valid = '0;
    tick();
    check("carry_sum", rsp_sum, 66'h3_FFFF_FFFF_FFFF_FFFE);
    check("carry_msb", rsp_sum[W], 1'b1);
    check("carry_lsb", rsp_sum[0], 1'b0);
    tick();

    // All requesters continuously valid for 8 accepts (pointer now 0).
    obs_id.delete();
    obs_cyc.delete();
    for (int i = 0; i < N; i++) set_req(i, operand_t'(100 * (i + 1)), operand_t'(i + 1));
    req_valid = 4'b1111;
    repeat (8) tick();
    req_valid = '0;
    repeat (3) tick();
    check_order("rr_all", '{0, 1, 2, 3, 0, 1, 2, 3});
    for (int k = 1; k < obs_cyc.size(); k++) check("rr_back_to_back", obs_cyc[k] - obs_cyc[k-1], 1);

    // Backpressure: two requests queue up behind a stalled output.
    obs_id.delete();
    rsp_ready = 1'b0;
    set_req(0, 11, 22);
    set_req(1, 33, 44);
    set_req(2, 55, 66);
    req_valid = 4'b0011;
    tick();
    req_valid = 4'b0010;
    tick();
    req_valid = 4'b0100;
    repeat (5) begin
      check("bp_req_ready", req_ready, 4'b0000);
      check("bp_rsp_id", rsp_id, 0);
      check("bp_rsp_sum", rsp_sum, 33);
      tick();
    end
`ifdef ADDER_ARB_STATS_EN
    check("bp_stall_cnt", stall_cnt, 5);
`endif
    rsp_ready = 1'b1;
    tick();
    req_valid = '0;
    repeat (4) tick();
    check_order("bp_order", '{0, 1, 2});

    // Sparse round-robin: pointer at 3, requesters 1 and 3.
    obs_id.delete();
    set_req(1, 1000, 1);
    set_req(3, 3000, 3);
    req_valid = 4'b1010;
    #1 check("sparse_first", req_ready, 4'b1000);
    tick();
    req_valid = 4'b0010;
    tick();
    req_valid = '0;
    repeat (3) tick();
    check_order("sparse_order", '{3, 1});
    req_valid = 4'b1111;
    #1 check("sparse_ptr_2", req_ready, 4'b0100);
    req_valid = '0;
    tick();

    // Asynchronous reset in the middle of a stream.
    for (int i = 0; i < N; i++) set_req(i, operand_t'(7 + i), operand_t'(9));
    req_valid = 4'b1111;
    repeat (3) tick();
    #2 rst = 1'b1;
    #1 check("arst_rsp_valid", rsp_valid, 1'b0);
    check("arst_req_ready", req_ready, 4'b0000);
`ifdef ADDER_ARB_STATS_EN
    check("arst_grant_cnt", grant_cnt, '0);
    check("arst_stall_cnt", stall_cnt, 0);
`endif
    req_valid = '0;
    tick();
    rst = 1'b0;
    tick();
    check("arst_idle", rsp_valid, 1'b0);
    set_req(1, 1, 1);
    req_valid = 4'b0010;
    tick();
    req_valid = '0;
    check("arst_no_stale", rsp_valid, 1'b0);
    tick();
    check("arst_rsp_valid", rsp_valid, 1'b1);
    check("arst_rsp_sum", rsp_sum, 2);
    check("arst_rsp_id", rsp_id, 1);
    tick();
    check("arst_drain", rsp_valid, 1'b0);
    repeat (2) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
